// File: rtl/phoenix_packet_sender.sv
// phoenix_packet_sender: local-port packet injector for the Phoenix NoC.
// Serializes a request into header flit, size flit and payload flits, and
// drives a router input port (rx/data_in) under that port's credit signal.

`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

module phoenix_packet_sender #(
  parameter int FLIT_W = `TAM_FLIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FLIT_W-1:0] req_target,
  input  logic [FLIT_W-1:0] req_size,
  input  logic              pl_valid,
  input  logic [FLIT_W-1:0] pl_data,
  output logic              pl_ready,
  input  logic              credit_i,
  output logic              tx,
  output logic [FLIT_W-1:0] data_out,
  output logic              busy,
  output logic              pkt_done,
  output logic              err_size
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    SIZE,
    PAYLOAD
  } state_t;

  state_t            r_state;
  logic [FLIT_W-1:0] r_target;
  logic [FLIT_W-1:0] r_size;
  logic [FLIT_W-1:0] r_remaining;
  logic              r_pktDone;
  logic              r_errSize;

  logic              w_reqReady;
  logic              w_plReady;
  logic              w_tx;
  logic [FLIT_W-1:0] w_dataOut;
  logic              w_accept;

  // Link-side outputs come straight from the state and the live credit/payload
  // inputs; reset forces every handshake low so an abandoned packet stops at once.
  always_comb begin
    w_reqReady = 1'b0;
    w_plReady  = 1'b0;
    w_tx       = 1'b0;
    w_dataOut  = '0;
    case (r_state)
      IDLE: begin
        w_reqReady = 1'b1;
      end
      HEADER: begin
        w_tx      = credit_i;
        w_dataOut = r_target;
      end
      SIZE: begin
        w_tx      = credit_i;
        w_dataOut = r_size;
      end
      PAYLOAD: begin
        w_plReady = credit_i;
        w_tx      = pl_valid & credit_i;
        w_dataOut = pl_data;
      end
      default: begin
        w_tx = 1'b0;
      end
    endcase
    if (reset) begin
      w_reqReady = 1'b0;
      w_plReady  = 1'b0;
      w_tx       = 1'b0;
    end
  end

  assign w_accept  = req_valid & w_reqReady;

  assign req_ready = w_reqReady;
  assign pl_ready  = w_plReady;
  assign tx        = w_tx;
  assign data_out  = w_dataOut;
  assign busy      = ~reset & (r_state != IDLE);
  assign pkt_done  = r_pktDone;
  assign err_size  = r_errSize;

  // Packet sequencer: advances only on a real flit transfer (tx high), so any
  // credit or payload stall simply holds the state and the flit on the wire.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_target    <= '0;
      r_size      <= '0;
      r_remaining <= '0;
      r_pktDone   <= 1'b0;
      r_errSize   <= 1'b0;
    end else begin
      r_pktDone <= 1'b0;
      r_errSize <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (req_size != '0) begin
              r_target <= req_target;
              r_size   <= req_size;
              r_state  <= HEADER;
            end else begin
              r_errSize <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (w_tx) begin
            r_state <= SIZE;
          end
        end
        SIZE: begin
          if (w_tx) begin
            r_remaining <= r_size;
            r_state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_tx) begin
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - FLIT_W'(1);
            end
            if (r_remaining == FLIT_W'(1)) begin
              r_state   <= IDLE;
              r_pktDone <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phoenix_packet_sender.sv
// Directed testbench for phoenix_packet_sender: each scenario is a short
// per-cycle table of inputs and hand-derived outputs.

module tb_phoenix_packet_sender;

  localparam int FW = 16;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic          rst;
    logic          reqV;
    logic [FW-1:0] tgt;
    logic [FW-1:0] sz;
    logic          cr;
    logic          plv;
    logic [FW-1:0] pld;
  } stim_t;

  typedef struct packed {
    logic          tx;
    logic          plRdy;
    logic          reqRdy;
    logic          busy;
    logic          done;
    logic          err;
    logic [FW-1:0] data;
  } obs_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [FW-1:0] req_target;
  logic [FW-1:0] req_size;
  logic          pl_valid;
  logic [FW-1:0] pl_data;
  logic          pl_ready;
  logic          credit_i;
  logic          tx;
  logic [FW-1:0] data_out;
  logic          busy;
  logic          pkt_done;
  logic          err_size;

  int nVectors     = 0;
  int nMiscompares = 0;

  phoenix_packet_sender #(.FLIT_W(FW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .req_size   (req_size),
    .pl_valid   (pl_valid),
    .pl_data    (pl_data),
    .pl_ready   (pl_ready),
    .credit_i   (credit_i),
    .tx         (tx),
    .data_out   (data_out),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .err_size   (err_size)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  function automatic stim_t st(input logic rst, input logic reqV,
                               input logic [FW-1:0] tgt, input logic [FW-1:0] sz,
                               input logic cr, input logic plv,
                               input logic [FW-1:0] pld);
    stim_t s;
    s.rst = rst; s.reqV = reqV; s.tgt = tgt; s.sz = sz;
    s.cr = cr; s.plv = plv; s.pld = pld;
    return s;
  endfunction

  function automatic obs_t ex(input logic etx, input logic epr, input logic err,
                              input logic ebusy, input logic edone,
                              input logic eerr, input logic [FW-1:0] edata);
    obs_t o;
    o.tx = etx; o.plRdy = epr; o.reqRdy = err; o.busy = ebusy;
    o.done = edone; o.err = eerr; o.data = edata;
    return o;
  endfunction

  // Drive one cycle's inputs just after the rising edge, sample outputs on the
  // falling edge, then move on to just after the next rising edge.
  task automatic applyStimulus(input stim_t s, output obs_t o);
    reset      = s.rst;
    req_valid  = s.reqV;
    req_target = s.tgt;
    req_size   = s.sz;
    credit_i   = s.cr;
    pl_valid   = s.plv;
    pl_data    = s.pld;
    @(negedge clock);
    o.tx     = tx;
    o.plRdy  = pl_ready;
    o.reqRdy = req_ready;
    o.busy   = busy;
    o.done   = pkt_done;
    o.err    = err_size;
    o.data   = data_out;
    @(posedge clock);
    #1;
  endtask

  // Reset holds every handshake low, then the sender settles into IDLE.
  task automatic test_reset();
    stim_t s [4];
    obs_t  e [4];
    obs_t  o;
    s[0] = st(H, H, 16'h00AA, 16'h0003, H, H, 16'h00BB); e[0] = ex(L, L, L, L, L, L, 16'h0000);
    s[1] = st(H, H, 16'h00AA, 16'h0003, H, H, 16'h00BB); e[1] = ex(L, L, L, L, L, L, 16'h0000);
    s[2] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[2] = ex(L, L, H, L, L, L, 16'h0000);
    s[3] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[3] = ex(L, L, H, L, L, L, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(s[i], o);
      nVectors++;
      if (o !== e[i]) begin
        nMiscompares++;
        $display("[TB] FAIL reset cycle %0d: got ctl=%b data=%h required ctl=%b data=%h",
                 i, o[21:16], o.data, e[i][21:16], e[i].data);
      end
    end
  endtask

  // Three-flit payload with full credit: five flits back to back, then done.
  task automatic test_basic();
    stim_t s [8];
    obs_t  e [8];
    obs_t  o;
    s[0] = st(L, H, 16'h0011, 16'h0003, H, H, 16'h00A1); e[0] = ex(L, L, H, L, L, L, 16'h0000);
    s[1] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00A1); e[1] = ex(H, L, L, H, L, L, 16'h0011);
    s[2] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00A1); e[2] = ex(H, L, L, H, L, L, 16'h0003);
    s[3] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00A1); e[3] = ex(H, H, L, H, L, L, 16'h00A1);
    s[4] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00A2); e[4] = ex(H, H, L, H, L, L, 16'h00A2);
    s[5] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00A3); e[5] = ex(H, H, L, H, L, L, 16'h00A3);
    s[6] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[6] = ex(L, L, H, L, H, L, 16'h0000);
    s[7] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[7] = ex(L, L, H, L, L, L, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(s[i], o);
      nVectors++;
      if (o !== e[i]) begin
        nMiscompares++;
        $display("[TB] FAIL basic cycle %0d: got ctl=%b data=%h required ctl=%b data=%h",
                 i, o[21:16], o.data, e[i][21:16], e[i].data);
      end
    end
  endtask

  // Credit withdrawn for three cycles while the size flit is on the wire.
  task automatic test_backpressure();
    stim_t s [10];
    obs_t  e [10];
    obs_t  o;
    s[0] = st(L, H, 16'h0022, 16'h0002, H, H, 16'h00B1); e[0] = ex(L, L, H, L, L, L, 16'h0000);
    s[1] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00B1); e[1] = ex(H, L, L, H, L, L, 16'h0022);
    s[2] = st(L, L, 16'h0000, 16'h0000, L, H, 16'h00B1); e[2] = ex(L, L, L, H, L, L, 16'h0002);
    s[3] = st(L, L, 16'h0000, 16'h0000, L, H, 16'h00B1); e[3] = ex(L, L, L, H, L, L, 16'h0002);
    s[4] = st(L, L, 16'h0000, 16'h0000, L, H, 16'h00B1); e[4] = ex(L, L, L, H, L, L, 16'h0002);
    s[5] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00B1); e[5] = ex(H, L, L, H, L, L, 16'h0002);
    s[6] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00B1); e[6] = ex(H, H, L, H, L, L, 16'h00B1);
    s[7] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00B2); e[7] = ex(H, H, L, H, L, L, 16'h00B2);
    s[8] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[8] = ex(L, L, H, L, H, L, 16'h0000);
    s[9] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[9] = ex(L, L, H, L, L, L, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(s[i], o);
      nVectors++;
      if (o !== e[i]) begin
        nMiscompares++;
        $display("[TB] FAIL backpressure cycle %0d: got ctl=%b data=%h required ctl=%b data=%h",
                 i, o[21:16], o.data, e[i][21:16], e[i].data);
      end
    end
  endtask

  // Payload source goes empty for two cycles after the first payload flit.
  task automatic test_starvation();
    stim_t s [10];
    obs_t  e [10];
    obs_t  o;
    s[0] = st(L, H, 16'h0033, 16'h0003, H, H, 16'h00C1); e[0] = ex(L, L, H, L, L, L, 16'h0000);
    s[1] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00C1); e[1] = ex(H, L, L, H, L, L, 16'h0033);
    s[2] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00C1); e[2] = ex(H, L, L, H, L, L, 16'h0003);
    s[3] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00C1); e[3] = ex(H, H, L, H, L, L, 16'h00C1);
    s[4] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h00C2); e[4] = ex(L, H, L, H, L, L, 16'h00C2);
    s[5] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h00C2); e[5] = ex(L, H, L, H, L, L, 16'h00C2);
    s[6] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00C2); e[6] = ex(H, H, L, H, L, L, 16'h00C2);
    s[7] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00C3); e[7] = ex(H, H, L, H, L, L, 16'h00C3);
    s[8] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[8] = ex(L, L, H, L, H, L, 16'h0000);
    s[9] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[9] = ex(L, L, H, L, L, L, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(s[i], o);
      nVectors++;
      if (o !== e[i]) begin
        nMiscompares++;
        $display("[TB] FAIL starvation cycle %0d: got ctl=%b data=%h required ctl=%b data=%h",
                 i, o[21:16], o.data, e[i][21:16], e[i].data);
      end
    end
  endtask

  // A zero-length request is swallowed with an error pulse; the next one runs.
  task automatic test_zero_size();
    stim_t s [8];
    obs_t  e [8];
    obs_t  o;
    s[0] = st(L, H, 16'h0044, 16'h0000, H, H, 16'h00D1); e[0] = ex(L, L, H, L, L, L, 16'h0000);
    s[1] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00D1); e[1] = ex(L, L, H, L, L, H, 16'h0000);
    s[2] = st(L, H, 16'h0055, 16'h0001, H, H, 16'h00D1); e[2] = ex(L, L, H, L, L, L, 16'h0000);
    s[3] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00D1); e[3] = ex(H, L, L, H, L, L, 16'h0055);
    s[4] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00D1); e[4] = ex(H, L, L, H, L, L, 16'h0001);
    s[5] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00D1); e[5] = ex(H, H, L, H, L, L, 16'h00D1);
    s[6] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[6] = ex(L, L, H, L, H, L, 16'h0000);
    s[7] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[7] = ex(L, L, H, L, L, L, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(s[i], o);
      nVectors++;
      if (o !== e[i]) begin
        nMiscompares++;
        $display("[TB] FAIL zero_size cycle %0d: got ctl=%b data=%h required ctl=%b data=%h",
                 i, o[21:16], o.data, e[i][21:16], e[i].data);
      end
    end
  endtask

  // Reset lands after two of five payload flits; the packet is dropped and a
  // fresh one-flit packet follows. data_out is left unchecked in the reset cycle.
  task automatic test_reset_mid_payload();
    stim_t s [13];
    obs_t  e [13];
    obs_t  o;
    s[0]  = st(L, H, 16'h0066, 16'h0005, H, H, 16'h00E1); e[0]  = ex(L, L, H, L, L, L, 16'h0000);
    s[1]  = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00E1); e[1]  = ex(H, L, L, H, L, L, 16'h0066);
    s[2]  = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00E1); e[2]  = ex(H, L, L, H, L, L, 16'h0005);
    s[3]  = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00E1); e[3]  = ex(H, H, L, H, L, L, 16'h00E1);
    s[4]  = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00E2); e[4]  = ex(H, H, L, H, L, L, 16'h00E2);
    s[5]  = st(H, L, 16'h0000, 16'h0000, H, H, 16'h00E3); e[5]  = ex(L, L, L, L, L, L, 16'h0000);
    s[6]  = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00E3); e[6]  = ex(L, L, H, L, L, L, 16'h0000);
    s[7]  = st(L, H, 16'h0077, 16'h0001, H, H, 16'h00F1); e[7]  = ex(L, L, H, L, L, L, 16'h0000);
    s[8]  = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00F1); e[8]  = ex(H, L, L, H, L, L, 16'h0077);
    s[9]  = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00F1); e[9]  = ex(H, L, L, H, L, L, 16'h0001);
    s[10] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h00F1); e[10] = ex(H, H, L, H, L, L, 16'h00F1);
    s[11] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[11] = ex(L, L, H, L, H, L, 16'h0000);
    s[12] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[12] = ex(L, L, H, L, L, L, 16'h0000);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(s[i], o);
      nVectors++;
      if ((o[21:16] !== e[i][21:16]) || ((i != 5) && (o.data !== e[i].data))) begin
        nMiscompares++;
        $display("[TB] FAIL reset_mid_payload cycle %0d: got ctl=%b data=%h required ctl=%b data=%h",
                 i, o[21:16], o.data, e[i][21:16], e[i].data);
      end
    end
  endtask

  // Two one-flit requests with req_valid held: 3 flits, one IDLE cycle, 3 flits.
  task automatic test_back_to_back();
    stim_t s [10];
    obs_t  e [10];
    obs_t  o;
    s[0] = st(L, H, 16'h0088, 16'h0001, H, H, 16'h0091); e[0] = ex(L, L, H, L, L, L, 16'h0000);
    s[1] = st(L, H, 16'h0099, 16'h0001, H, H, 16'h0091); e[1] = ex(H, L, L, H, L, L, 16'h0088);
    s[2] = st(L, H, 16'h0099, 16'h0001, H, H, 16'h0091); e[2] = ex(H, L, L, H, L, L, 16'h0001);
    s[3] = st(L, H, 16'h0099, 16'h0001, H, H, 16'h0091); e[3] = ex(H, H, L, H, L, L, 16'h0091);
    s[4] = st(L, H, 16'h0099, 16'h0001, H, H, 16'h0092); e[4] = ex(L, L, H, L, H, L, 16'h0000);
    s[5] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h0092); e[5] = ex(H, L, L, H, L, L, 16'h0099);
    s[6] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h0092); e[6] = ex(H, L, L, H, L, L, 16'h0001);
    s[7] = st(L, L, 16'h0000, 16'h0000, H, H, 16'h0092); e[7] = ex(H, H, L, H, L, L, 16'h0092);
    s[8] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[8] = ex(L, L, H, L, H, L, 16'h0000);
    s[9] = st(L, L, 16'h0000, 16'h0000, H, L, 16'h0000); e[9] = ex(L, L, H, L, L, L, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(s[i], o);
      nVectors++;
      if (o !== e[i]) begin
        nMiscompares++;
        $display("[TB] FAIL back_to_back cycle %0d: got ctl=%b data=%h required ctl=%b data=%h",
                 i, o[21:16], o.data, e[i][21:16], e[i].data);
      end
    end
  endtask

  // Scenario sequence, starting from reset asserted at time zero.
  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_target = '0;
    req_size   = '0;
    pl_valid   = 1'b0;
    pl_data    = '0;
    credit_i   = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_zero_size();
    test_reset_mid_payload();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  // Safety net so the run can never stall indefinitely.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
